// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART transmitter among
//               REQ_NUM byte requesters. Supports bounded bursts per grant
//               and an optional SEND watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int REQ_NUM        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int BURST_LEN      = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                          clk_i,
    input  logic                          a_rst_n_i,
    input  logic                          en_i,
    input  logic [REQ_NUM-1:0]            req_valid_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data_i,
    output logic [REQ_NUM-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    output logic                          tx_enable_o,
    input  logic                          tx_complete_i,
    output logic [$clog2(REQ_NUM)-1:0]    grant_id_o,
    output logic                          busy_o,
    output logic                          error_o
);

    localparam int ID_W  = $clog2(REQ_NUM);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(REQ_NUM - 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
    localparam logic [WD_W-1:0]  WD_LAST   = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ID_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]      burst_cnt;
    logic [WD_W-1:0]       wd_cnt;
    logic [ID_W-1:0]       pick_id;
    logic [ID_W-1:0]       scan_id;
    logic                  pick_found;
    logic                  continue_burst;
    logic                  timeout;
    logic                  release_grant;
    logic [ID_W-1:0]       next_ptr;
    logic [DATA_WIDTH-1:0] req_bytes [REQ_NUM];

    // Split the flat data bus into one byte per requester.
    for (genvar g = 0; g < REQ_NUM; g++) begin : g_unpack
        assign req_bytes[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Circular search for the first pending requester starting at rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = rr_ptr;
        scan_id    = rr_ptr;
        for (int k = 0; k < REQ_NUM; k++) begin
            scan_id = ID_W'((int'(rr_ptr) + k) % REQ_NUM);
            if (!pick_found && req_valid_i[scan_id]) begin
                pick_found = 1'b1;
                pick_id    = scan_id;
            end
        end
    end

    // Burst continuation, watchdog expiry and grant release conditions.
    always_comb begin
        continue_burst = req_valid_i[grant_id_o] && (burst_cnt < BURST_MAX) && en_i;
        timeout        = (TIMEOUT_CYCLES > 0) && (state == SEND) && !tx_complete_i
                         && (wd_cnt == WD_LAST);
        release_grant  = ((state == GAP) && !continue_burst) || timeout;
        next_ptr       = (grant_id_o == LAST_ID) ? '0 : grant_id_o + ID_W'(1);
    end

    // State register; reset drops the state and thus all state-decoded outputs at once.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt   = state;
        req_ready_o = '0;
        tx_enable_o = 1'b0;
        busy_o      = (state != IDLE);
        case (state)
            IDLE: begin
                if (en_i && pick_found) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                req_ready_o = REQ_NUM'(1) << grant_id_o;
                state_nxt   = SEND;
            end
            SEND: begin
                tx_enable_o = 1'b1;
                if (tx_complete_i) begin
                    state_nxt = GAP;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                state_nxt = continue_burst ? LOAD : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant, data capture, burst/watchdog counters and round-robin pointer.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            wd_cnt     <= '0;
            grant_id_o <= '0;
            tx_data_o  <= '0;
            error_o    <= 1'b0;
        end else begin
            error_o <= timeout;
            wd_cnt  <= (state == SEND) ? wd_cnt + WD_W'(1) : '0;
            if ((state == IDLE) && (state_nxt == LOAD)) begin
                grant_id_o <= pick_id;
            end
            if (state == LOAD) begin
                tx_data_o <= req_bytes[grant_id_o];
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
            if (release_grant) begin
                rr_ptr    <= next_ptr;
                burst_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter with requester,
//               transmitter models and a grant scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int REQ_NUM  = 4;
    localparam int DW       = 8;
    localparam int BURST    = 2;
    localparam int TIMEOUT  = 50;
    localparam int TX_DELAY = 20;

    logic                   clk_i = 1'b0;
    logic                   a_rst_n_i;
    logic                   en_i;
    logic [REQ_NUM-1:0]     req_valid_i;
    logic [REQ_NUM*DW-1:0]  req_data_i;
    logic [REQ_NUM-1:0]     req_ready_o;
    logic [DW-1:0]          tx_data_o;
    logic                   tx_enable_o;
    logic                   tx_complete_i;
    logic [1:0]             grant_id_o;
    logic                   busy_o;
    logic                   error_o;

    uart_tx_arbiter #(
        .REQ_NUM        (REQ_NUM),
        .DATA_WIDTH     (DW),
        .BURST_LEN      (BURST),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_i         (clk_i),
        .a_rst_n_i     (a_rst_n_i),
        .en_i          (en_i),
        .req_valid_i   (req_valid_i),
        .req_data_i    (req_data_i),
        .req_ready_o   (req_ready_o),
        .tx_data_o     (tx_data_o),
        .tx_enable_o   (tx_enable_o),
        .tx_complete_i (tx_complete_i),
        .grant_id_o    (grant_id_o),
        .busy_o        (busy_o),
        .error_o       (error_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected grant: requester, byte, idle-run before LOAD (0 = any),
    // ticks from valid rise to ready (0 = any).
    typedef struct {
        int        id;
        logic [7:0] data;
        int        run;
        int        lat;
    } exp_t;

    exp_t       sb_q [$];
    int         checks = 0;
    int         errors = 0;
    int         accepted = 0;
    int         tick = 0;
    bit         never_complete = 1'b0;
    bit         data_pend = 1'b0;

    logic [7:0] src_mem   [REQ_NUM][32];
    int         src_head  [REQ_NUM];
    int         src_tail  [REQ_NUM];
    bit         pop_flag  [REQ_NUM];
    int         rise_tick [REQ_NUM];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add_byte(input int id, input logic [7:0] d);
        src_mem[id][src_tail[id]] = d;
        src_tail[id]++;
    endtask

    task automatic push_exp(input int id, input logic [7:0] d, input int run, input int lat);
        exp_t e;
        e.id = id; e.data = d; e.run = run; e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!(sb_q.size() == 0 && busy_o == 1'b0 && !data_pend)) begin
            @(posedge clk_i); #2;
            n++;
            if (n > budget) begin
                chk("wait_done_timeout", 32'(sb_q.size()), 32'd0);
                return;
            end
        end
    endtask

    task automatic wait_en(input int budget);
        int n = 0;
        while (tx_enable_o !== 1'b1) begin
            @(posedge clk_i); #2;
            n++;
            if (n > budget) begin
                chk("wait_tx_enable_timeout", 32'(tx_enable_o), 32'd1);
                return;
            end
        end
    endtask

    task automatic wait_accept(input int target, input int budget);
        int n = 0;
        while (accepted < target) begin
            @(posedge clk_i); #2;
            n++;
            if (n > budget) begin
                chk("wait_accept_timeout", 32'(accepted), 32'(target));
                return;
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    // Transmitter model: complete pulse after TX_DELAY cycles of enable.
    initial begin
        int cnt = 0;
        tx_complete_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            if (tx_enable_o) cnt++;
            else cnt = 0;
            tx_complete_i = tx_enable_o && !never_complete && (cnt == TX_DELAY);
        end
    end

    // Requester model plus output monitor/scoreboard.
    initial begin
        logic [REQ_NUM-1:0]    nv;
        logic [REQ_NUM*DW-1:0] nd;
        logic [REQ_NUM-1:0]    exp_ready;
        exp_t e;
        bit   prev_en = 1'b0;
        bit   exp_err;
        int   send_len = 0;
        int   idle_run = 0;
        logic [7:0] exp_data = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            src_head[i] = 0; src_tail[i] = 0; pop_flag[i] = 1'b0; rise_tick[i] = 0;
        end
        req_valid_i = '0;
        req_data_i  = '0;
        forever begin
            @(posedge clk_i); #1;
            tick++;
            for (int i = 0; i < REQ_NUM; i++) begin
                if (pop_flag[i]) begin
                    src_head[i]++;
                    pop_flag[i] = 1'b0;
                end
            end
            if (!a_rst_n_i) begin
                prev_en = 1'b0; send_len = 0; idle_run = 0; data_pend = 1'b0;
            end else begin
                if (data_pend) begin
                    chk("tx_enable_after_ready", 32'(tx_enable_o), 32'd1);
                    chk("tx_data", 32'(tx_data_o), 32'(exp_data));
                    data_pend = 1'b0;
                end
                if (tx_enable_o) begin
                    send_len++;
                    idle_run = 0;
                end else begin
                    if (prev_en) begin
                        exp_err = never_complete;
                        chk("error_at_send_end", 32'(error_o), 32'(exp_err));
                        chk("send_len", 32'(send_len), exp_err ? 32'(TIMEOUT) : 32'(TX_DELAY));
                        send_len = 0;
                    end else if (error_o) begin
                        chk("stray_error", 32'(error_o), 32'd0);
                    end
                    idle_run++;
                end
                if (req_ready_o != '0) begin
                    chk("ready_onehot", 32'($countones(req_ready_o)), 32'd1);
                    if (sb_q.size() == 0) begin
                        chk("unexpected_grant", 32'(req_ready_o), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        exp_ready = '0;
                        exp_ready[e.id] = 1'b1;
                        chk("ready_vector", 32'(req_ready_o), 32'(exp_ready));
                        chk("grant_id", 32'(grant_id_o), 32'(e.id));
                        if (e.run != 0) chk("idle_run", 32'(idle_run), 32'(e.run));
                        if (e.lat != 0) chk("ready_latency", 32'(tick - rise_tick[e.id]), 32'(e.lat));
                        exp_data  = e.data;
                        data_pend = 1'b1;
                        accepted++;
                    end
                    for (int i = 0; i < REQ_NUM; i++) begin
                        if (req_ready_o[i]) pop_flag[i] = 1'b1;
                    end
                end
                prev_en = tx_enable_o;
            end
            nd = '0;
            for (int i = 0; i < REQ_NUM; i++) begin
                nv[i] = (src_head[i] != src_tail[i]);
                if (nv[i] && !req_valid_i[i]) rise_tick[i] = tick;
                if (nv[i]) nd[i*DW +: DW] = src_mem[i][src_head[i]];
            end
            req_valid_i = nv;
            req_data_i  = nd;
        end
    end

    // Hard stop if the run never finishes.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    // Directed test sequence.
    initial begin
        exp_t vec [4];
        int   acc0;
        a_rst_n_i = 1'b0;
        en_i      = 1'b1;

        // Reset state
        cycles(3);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_tx_enable", 32'(tx_enable_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_grant", 32'(grant_id_o), 32'd0);
        chk("rst_tx_data", 32'(tx_data_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        a_rst_n_i = 1'b1;
        cycles(2);

        // Single requesters from idle; order leaves rr_ptr at 0 (3 wraps to 0).
        vec[0] = '{id: 2, data: 8'hA5, run: 0, lat: 1};
        vec[1] = '{id: 0, data: 8'h3C, run: 0, lat: 1};
        vec[2] = '{id: 1, data: 8'h5A, run: 0, lat: 1};
        vec[3] = '{id: 3, data: 8'hFF, run: 0, lat: 1};
        for (int v = 0; v < 4; v++) begin
            sb_q.push_back(vec[v]);
            add_byte(vec[v].id, vec[v].data);
            wait_done(200);
            chk("single_back_to_idle", 32'(busy_o), 32'd0);
            cycles(3);
        end

        // Round-robin 0,1,3 then 0 again after the pointer wraps.
        acc0 = accepted;
        push_exp(0, 8'h11, 0, 1);
        push_exp(1, 8'h22, 3, 0);
        push_exp(3, 8'h33, 3, 0);
        push_exp(0, 8'h44, 3, 0);
        add_byte(0, 8'h11); add_byte(1, 8'h22); add_byte(3, 8'h33);
        wait_accept(acc0 + 2, 200);
        add_byte(0, 8'h44);
        wait_done(500);
        cycles(3);

        // Burst limit of 2 with a competing requester.
        push_exp(1, 8'hB0, 0, 1);
        push_exp(1, 8'hB1, 2, 0);
        push_exp(2, 8'hC0, 3, 0);
        push_exp(1, 8'hB2, 3, 0);
        push_exp(1, 8'hB3, 2, 0);
        push_exp(1, 8'hB4, 3, 0);
        for (int b = 0; b < 5; b++) add_byte(1, 8'hB0 + 8'(b));
        add_byte(2, 8'hC0);
        wait_done(800);
        cycles(3);

        // Enable dropped mid-SEND: frame finishes, then nothing until re-enabled.
        push_exp(1, 8'hD0, 0, 1);
        add_byte(1, 8'hD0);
        wait_en(50);
        cycles(3);
        en_i = 1'b0;
        add_byte(1, 8'hD1);
        add_byte(2, 8'hE0);
        wait_done(100);
        acc0 = accepted;
        cycles(30);
        chk("en_low_busy", 32'(busy_o), 32'd0);
        chk("en_low_no_grant", 32'(accepted), 32'(acc0));
        push_exp(2, 8'hE0, 0, 0);
        push_exp(1, 8'hD1, 3, 0);
        en_i = 1'b1;
        wait_done(300);
        cycles(3);

        // Watchdog: first frame never completes.
        never_complete = 1'b1;
        push_exp(2, 8'hF0, 0, 1);
        push_exp(3, 8'hF1, 2, 0);
        add_byte(2, 8'hF0); add_byte(3, 8'hF1);
        begin
            int n = 0;
            while (error_o !== 1'b1 && n < 150) begin
                @(posedge clk_i); #2;
                n++;
            end
        end
        chk("wd_error_seen", 32'(error_o), 32'd1);
        chk("wd_tx_enable_dropped", 32'(tx_enable_o), 32'd0);
        chk("wd_released_idle", 32'(busy_o), 32'd0);
        never_complete = 1'b0;
        wait_done(300);
        cycles(3);

        // Async reset mid-SEND with pointer away from 0.
        push_exp(1, 8'h70, 0, 1);
        add_byte(1, 8'h70);
        wait_done(200);
        cycles(2);
        push_exp(3, 8'h77, 0, 1);
        add_byte(3, 8'h77);
        wait_en(50);
        cycles(5);
        add_byte(0, 8'h81); add_byte(1, 8'h82); add_byte(2, 8'h83);
        cycles(2);
        #1;
        a_rst_n_i = 1'b0;
        #1;
        chk("arst_tx_enable", 32'(tx_enable_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_ready", 32'(req_ready_o), 32'd0);
        chk("arst_tx_data", 32'(tx_data_o), 32'd0);
        chk("arst_grant", 32'(grant_id_o), 32'd0);
        chk("arst_error", 32'(error_o), 32'd0);
        chk("arst_sb_empty", 32'(sb_q.size()), 32'd0);
        repeat (3) @(posedge clk_i);
        push_exp(0, 8'h81, 0, 0);
        push_exp(1, 8'h82, 3, 0);
        push_exp(2, 8'h83, 3, 0);
        #3;
        a_rst_n_i = 1'b1;
        wait_done(400);
        cycles(5);
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter REQ_NUM, default 4, SHALL set the number of requester ports (2..16).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the byte width passed to the UART transmitter.
REQ-003 Parameter BURST_LEN, default 4, SHALL set the maximum consecutive bytes per grant (>=1).
REQ-004 Parameter TIMEOUT_CYCLES, default 0, SHALL set the SEND watchdog limit (0 = watchdog disabled).
REQ-005 Port list SHALL be:
- clk_i, input, 1, single clock; all logic on its rising edge.
- a_rst_n_i, input, 1, asynchronous active-low reset.
- en_i, input, 1, global enable for new grants.
- req_valid_i, input, REQ_NUM, per-requester byte pending.
- req_data_i, input, REQ_NUM*DATA_WIDTH, byte of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o, output, REQ_NUM, one-hot, one-cycle acceptance pulse.
- tx_data_o, output, DATA_WIDTH, byte to the transmitter's parallel input.
- tx_enable_o, output, 1, transmitter enable.
- tx_complete_i, input, 1, one-cycle pulse from the transmitter at end of stop bit(s).
- grant_id_o, output, $clog2(REQ_NUM), current owner index.
- busy_o, output, 1, high whenever state != IDLE.
- error_o, output, 1, one-cycle watchdog-abort pulse.

Function
REQ-006 FSM states SHALL be IDLE, LOAD, SEND, GAP; exactly one state per cycle.
REQ-007 IDLE: when en_i=1 and any req_valid_i bit is set, the arbiter SHALL register grant_id_o = first set index searching circularly from rr_ptr, then move to LOAD; otherwise it SHALL stay in IDLE.
REQ-008 LOAD (one cycle): tx_data_o SHALL register req_data_i of the granted requester, req_ready_o[grant] SHALL be 1 for this cycle only, burst_cnt SHALL increment, and the next state SHALL be SEND.
REQ-009 SEND: tx_enable_o SHALL be 1 and tx_data_o SHALL be held stable; on tx_complete_i=1 the next state SHALL be GAP.
REQ-010 GAP (one cycle, tx_enable_o=0): if req_valid_i[grant]=1, burst_cnt<BURST_LEN and en_i=1, the next state SHALL be LOAD with the same grant; otherwise rr_ptr SHALL be set to (grant+1) mod REQ_NUM, burst_cnt SHALL be cleared, and the next state SHALL be IDLE.
REQ-011 Latency: req_valid_i rising in IDLE at edge N SHALL give req_ready_o at cycle N+1 and tx_enable_o=1 from cycle N+2.
REQ-012 Requesters SHALL hold req_valid_i and req_data_i stable until req_ready_o; the arbiter SHALL accept in LOAD without rechecking valid.
REQ-013 Deasserting req_valid_i during SEND SHALL NOT affect the byte in flight.
REQ-014 tx_complete_i outside SEND SHALL be ignored.
REQ-015 en_i=0 SHALL block new grants in IDLE and burst continuation in GAP, but SHALL NOT abort a frame in SEND.
REQ-016 When TIMEOUT_CYCLES>0 and SEND lasts TIMEOUT_CYCLES cycles without tx_complete_i, the arbiter SHALL:
- pulse error_o for one cycle;
- drop tx_enable_o;
- release the grant as in REQ-010 and go to IDLE.
REQ-017 rr_ptr SHALL wrap from REQ_NUM-1 to 0; a sole active requester SHALL be regranted after release.
REQ-018 req_ready_o SHALL never have more than one bit set.

Reset
REQ-019 On a_rst_n_i=0, immediately and regardless of clock, the following SHALL be 0: state (IDLE), rr_ptr, burst_cnt, watchdog count, req_ready_o, tx_data_o, tx_enable_o, grant_id_o, busy_o, error_o.
REQ-020 Reset asserted mid-SEND SHALL drop tx_enable_o asynchronously; after release the arbiter SHALL restart from IDLE with rr_ptr=0.

Verification
REQ-021 A bench SHALL cover these directed scenarios (REQ_NUM=4, BURST_LEN=2, transmitter model pulses tx_complete_i 20 cycles after tx_enable_o rises):
- Single requester: req 2 valid with 0xA5 -> ready_o=4'b0100 one cycle, tx_data_o=0xA5, grant_id_o=2, tx_enable_o high until complete, then IDLE.
- Round-robin: reqs 0,1,3 continuously valid with one byte each -> service order 0,1,3,0, rr_ptr wraps 3->0.
- Burst limit: req 1 holds valid for 5 bytes while req 2 valid -> order 1,1,2,1,1,1; exactly one GAP cycle between each pair of bytes.
- Enable: en_i dropped mid-SEND -> current frame completes, no new grant until en_i=1.
- Watchdog: TIMEOUT_CYCLES=50, model never completes -> error_o pulses at SEND cycle 50, tx_enable_o=0, next requester granted.
- Async reset mid-SEND -> all outputs 0 without a clock edge; first grant after release goes to req 0 when all are valid.
